// File: rtl/ifmap_bank_switch_scheduler_if.sv
// Handshake bundle between the ifmap bank-switch scheduler and the write/read sides.
// The slave modport is the scheduler; the master modport drives the request inputs.
interface ifmap_bank_switch_scheduler_if #(
    parameter int COUNTER_WID = 8
);
    logic                   start;
    logic                   write_bank_ready_to_switch;
    logic                   reading_last_data;
    logic                   ready_to_switch;
    logic                   start_new_write_bank;
    logic                   read_bank_valid;
    logic [COUNTER_WID-1:0] read_pass_count;
    logic [COUNTER_WID-1:0] write_bank_count;
    logic                   busy;
    logic                   layer_done;

    modport master (
        output start,
        output write_bank_ready_to_switch,
        output reading_last_data,
        input  ready_to_switch,
        input  start_new_write_bank,
        input  read_bank_valid,
        input  read_pass_count,
        input  write_bank_count,
        input  busy,
        input  layer_done
    );

    modport slave (
        input  start,
        input  write_bank_ready_to_switch,
        input  reading_last_data,
        output ready_to_switch,
        output start_new_write_bank,
        output read_bank_valid,
        output read_pass_count,
        output write_bank_count,
        output busy,
        output layer_done
    );
endinterface

// File: rtl/ifmap_bank_switch_scheduler.sv
// Sequences the ifmap double buffer for one layer: bank swaps, pass counting, layer completion.
//
// state    | meaning
// ST_IDLE  | waiting for start; all outputs 0
// ST_FILL  | first write bank filling; nothing readable yet
// ST_RUN   | read bank in use while next write bank fills
// ST_DRAIN | last bank swapped in; finishing its read passes
// ST_DONE  | one-cycle layer_done, then back to IDLE
module ifmap_bank_switch_scheduler #(
    parameter int OY1_OX1     = 2,
    parameter int READ_PASSES = 2,
    parameter int COUNTER_WID = 8
) (
    input logic                             clk,
    input logic                             rst,
    ifmap_bank_switch_scheduler_if.slave    sched
);

    localparam logic [COUNTER_WID-1:0] BANKS_C  = COUNTER_WID'(OY1_OX1);
    localparam logic [COUNTER_WID-1:0] PASSES_C = COUNTER_WID'(READ_PASSES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   ready_to_switch_q, ready_to_switch_d;
    logic                   start_new_write_bank_q, start_new_write_bank_d;
    logic                   read_bank_valid_q, read_bank_valid_d;
    logic                   busy_q, busy_d;
    logic                   layer_done_q, layer_done_d;
    logic [COUNTER_WID-1:0] read_pass_count_q, read_pass_count_d;
    logic [COUNTER_WID-1:0] write_bank_count_q, write_bank_count_d;

    logic                   read_done;
    logic                   swap_cond;
    logic                   pass_inc;
    logic [COUNTER_WID-1:0] write_bank_count_inc;
    logic                   last_bank;

    // Swap decisions use only registered read state so a pass ending this cycle defers the swap.
    assign read_done            = (read_pass_count_q == PASSES_C);
    assign swap_cond            = sched.write_bank_ready_to_switch && !read_bank_valid_q;
    assign pass_inc             = read_bank_valid_q && sched.reading_last_data && !read_done &&
                                  ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    assign write_bank_count_inc = write_bank_count_q + 1'b1;
    assign last_bank            = (write_bank_count_inc >= BANKS_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                <= ST_IDLE;
            ready_to_switch_q      <= 1'b0;
            start_new_write_bank_q <= 1'b0;
            read_bank_valid_q      <= 1'b0;
            busy_q                 <= 1'b0;
            layer_done_q           <= 1'b0;
            read_pass_count_q      <= '0;
            write_bank_count_q     <= '0;
        end else begin
            state_q                <= state_d;
            ready_to_switch_q      <= ready_to_switch_d;
            start_new_write_bank_q <= start_new_write_bank_d;
            read_bank_valid_q      <= read_bank_valid_d;
            busy_q                 <= busy_d;
            layer_done_q           <= layer_done_d;
            read_pass_count_q      <= read_pass_count_d;
            write_bank_count_q     <= write_bank_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (sched.start) state_d = ST_FILL;
            ST_FILL,
            ST_RUN:   if (swap_cond) state_d = last_bank ? ST_DRAIN : ST_RUN;
            ST_DRAIN: if (read_done) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_to_switch_d      = 1'b0;
        start_new_write_bank_d = 1'b0;
        read_pass_count_d      = read_pass_count_q;
        write_bank_count_d     = write_bank_count_q;
        case (state_q)
            ST_IDLE: begin
                read_pass_count_d      = '0;
                write_bank_count_d     = '0;
                start_new_write_bank_d = sched.start;
            end
            ST_FILL, ST_RUN: begin
                if (swap_cond) begin
                    ready_to_switch_d      = 1'b1;
                    write_bank_count_d     = write_bank_count_inc;
                    read_pass_count_d      = '0;
                    start_new_write_bank_d = !last_bank;
                end else if (pass_inc) begin
                    read_pass_count_d = read_pass_count_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (pass_inc) read_pass_count_d = read_pass_count_q + 1'b1;
            end
            default: ;
        endcase
        if (state_d == ST_IDLE) begin
            read_pass_count_d  = '0;
            write_bank_count_d = '0;
        end
        read_bank_valid_d = ((state_d == ST_RUN) || (state_d == ST_DRAIN)) &&
                            (read_pass_count_d != PASSES_C);
        busy_d            = (state_d != ST_IDLE);
        layer_done_d      = (state_d == ST_DONE);
    end

    assign sched.ready_to_switch      = ready_to_switch_q;
    assign sched.start_new_write_bank = start_new_write_bank_q;
    assign sched.read_bank_valid      = read_bank_valid_q;
    assign sched.busy                 = busy_q;
    assign sched.layer_done           = layer_done_q;
    assign sched.read_pass_count      = read_pass_count_q;
    assign sched.write_bank_count     = write_bank_count_q;

endmodule

// File: tb/tb_ifmap_bank_switch_scheduler.sv
// Directed bench for the ifmap bank-switch scheduler: a 2-bank layer and a 1-bank layer instance.
module tb_ifmap_bank_switch_scheduler;

    localparam int W = 8;
    localparam logic [4:0] F_RTS  = 5'b10000;
    localparam logic [4:0] F_SNWB = 5'b01000;
    localparam logic [4:0] F_RBV  = 5'b00100;
    localparam logic [4:0] F_BUSY = 5'b00010;
    localparam logic [4:0] F_LD   = 5'b00001;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   rts_cnt1 = 0;
    int   snwb_cnt1 = 0;

    always #5 clk = ~clk;

    ifmap_bank_switch_scheduler_if #(.COUNTER_WID(W)) sif0 ();
    ifmap_bank_switch_scheduler_if #(.COUNTER_WID(W)) sif1 ();

    ifmap_bank_switch_scheduler #(.OY1_OX1(2), .READ_PASSES(2), .COUNTER_WID(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .sched (sif0)
    );

    ifmap_bank_switch_scheduler #(.OY1_OX1(1), .READ_PASSES(2), .COUNTER_WID(W)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .sched (sif1)
    );

    always @(negedge clk) begin
        if (sif1.ready_to_switch)      rts_cnt1++;
        if (sif1.start_new_write_bank) snwb_cnt1++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] flags0();
        return {sif0.ready_to_switch, sif0.start_new_write_bank, sif0.read_bank_valid,
                sif0.busy, sif0.layer_done};
    endfunction

    function automatic logic [4:0] flags1();
        return {sif1.ready_to_switch, sif1.start_new_write_bank, sif1.read_bank_valid,
                sif1.busy, sif1.layer_done};
    endfunction

    task automatic chk0(input string tag, input logic [4:0] f, input int rpc, input int wbc);
        chk({tag, ".flags"}, 32'(flags0()), 32'(f));
        chk({tag, ".rpc"}, 32'(sif0.read_pass_count), rpc);
        chk({tag, ".wbc"}, 32'(sif0.write_bank_count), wbc);
    endtask

    task automatic chk1(input string tag, input logic [4:0] f, input int rpc, input int wbc);
        chk({tag, ".flags"}, 32'(flags1()), 32'(f));
        chk({tag, ".rpc"}, 32'(sif1.read_pass_count), rpc);
        chk({tag, ".wbc"}, 32'(sif1.write_bank_count), wbc);
    endtask

    // Inputs change 1 time unit after the edge, outputs are sampled at the same point.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start0();
        sif0.start = 1'b1; tick(); sif0.start = 1'b0;
    endtask

    task automatic pulse_rld0();
        sif0.reading_last_data = 1'b1; tick(); sif0.reading_last_data = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sif0.start = 1'b0; sif0.write_bank_ready_to_switch = 1'b0; sif0.reading_last_data = 1'b0;
        sif1.start = 1'b0; sif1.write_bank_ready_to_switch = 1'b0; sif1.reading_last_data = 1'b0;
        tick(2);
        chk0("reset", 5'b0, 0, 0);
        chk1("reset1", 5'b0, 0, 0);
        rst = 1'b0;
        tick();

        // Nominal two-bank layer with a late read on the second swap
        pulse_start0();
        chk0("start", F_SNWB | F_BUSY, 0, 0);
        sif0.reading_last_data = 1'b1;
        sif0.start = 1'b1;
        tick();
        chk0("fill_spurious", F_BUSY, 0, 0);
        sif0.reading_last_data = 1'b0;
        sif0.start = 1'b0;
        tick(5);
        chk0("fill_wait", F_BUSY, 0, 0);
        sif0.write_bank_ready_to_switch = 1'b1;
        tick();
        chk0("swap1", F_RTS | F_SNWB | F_RBV | F_BUSY, 0, 1);
        sif0.write_bank_ready_to_switch = 1'b0;
        tick();
        chk0("run", F_RBV | F_BUSY, 0, 1);
        pulse_rld0();
        chk0("pass1", F_RBV | F_BUSY, 1, 1);
        sif0.write_bank_ready_to_switch = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk0("late_read_hold", F_RBV | F_BUSY, 1, 1);
        end
        pulse_rld0();
        chk0("pass2_no_swap", F_BUSY, 2, 1);
        tick();
        chk0("swap2", F_RTS | F_RBV | F_BUSY, 0, 2);
        sif0.write_bank_ready_to_switch = 1'b0;
        pulse_rld0();
        chk0("drain_pass1", F_RBV | F_BUSY, 1, 2);
        pulse_rld0();
        chk0("drain_pass2", F_BUSY, 2, 2);
        tick();
        chk0("done", F_BUSY | F_LD, 2, 2);
        tick();
        chk0("idle_after", 5'b0, 0, 0);

        // Late write: read finishes, write side full 5 cycles later
        pulse_start0();
        sif0.write_bank_ready_to_switch = 1'b1;
        tick();
        chk0("lw_swap1", F_RTS | F_SNWB | F_RBV | F_BUSY, 0, 1);
        sif0.write_bank_ready_to_switch = 1'b0;
        pulse_rld0();
        pulse_rld0();
        chk0("lw_read_done", F_BUSY, 2, 1);
        tick(2);
        pulse_rld0();
        chk0("lw_spurious_rld", F_BUSY, 2, 1);
        tick(2);
        chk0("lw_stall", F_BUSY, 2, 1);
        sif0.write_bank_ready_to_switch = 1'b1;
        tick();
        chk0("lw_swap2", F_RTS | F_RBV | F_BUSY, 0, 2);
        sif0.write_bank_ready_to_switch = 1'b0;
        pulse_rld0();
        chk0("lw_drain", F_RBV | F_BUSY, 1, 2);

        // Reset held two cycles in DRAIN abandons the layer
        rst = 1'b1;
        sif0.start = 1'b1;
        tick();
        chk0("rst_drain1", 5'b0, 0, 0);
        tick();
        chk0("rst_drain2", 5'b0, 0, 0);
        rst = 1'b0;
        sif0.start = 1'b0;
        tick();
        chk0("rst_idle", 5'b0, 0, 0);
        pulse_start0();
        chk0("restart", F_SNWB | F_BUSY, 0, 0);

        // Single-bank layer on the second instance
        sif1.start = 1'b1; tick(); sif1.start = 1'b0;
        chk1("b1_start", F_SNWB | F_BUSY, 0, 0);
        tick(3);
        sif1.write_bank_ready_to_switch = 1'b1;
        tick();
        chk1("b1_swap", F_RTS | F_RBV | F_BUSY, 0, 1);
        sif1.write_bank_ready_to_switch = 1'b0;
        sif1.reading_last_data = 1'b1; tick(); sif1.reading_last_data = 1'b0;
        chk1("b1_pass1", F_RBV | F_BUSY, 1, 1);
        sif1.reading_last_data = 1'b1; tick(); sif1.reading_last_data = 1'b0;
        chk1("b1_pass2", F_BUSY, 2, 1);
        tick();
        chk1("b1_done", F_BUSY | F_LD, 2, 1);
        tick();
        chk1("b1_idle", 5'b0, 0, 0);
        tick();
        chk("b1_rts_total", rts_cnt1, 1);
        chk("b1_snwb_total", snwb_cnt1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
